irt_dep_table: RTL and testbench

//  Parametrised instruction register table (IRT) with RAW dependency tracking.

---
 rtl/irt_pkg.sv | 21 ++
 rtl/irt_writer_map.sv | 62 ++++++
 rtl/irt_dep_table.sv | 142 ++++++++++++++
 tb/tb_irt_dep_table.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irt_pkg.sv
// Shared types and sizes for the instruction register table with RAW dependency tracking.
// The table and the writer map are both sized from IRT_BS / IRT_REGNUM.
package irt_pkg;
    localparam int IRT_BS     = 16;
    localparam int IRT_REGNUM = 16;
    localparam int IDX_W      = $clog2(IRT_BS);
    localparam int REG_W      = $clog2(IRT_REGNUM);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [REG_W-1:0] reg_t;

    typedef struct packed {
        logic              valid;
        reg_t              rd;
        reg_t              rs1;
        reg_t              rs2;
        logic [IRT_BS-1:0] dep;
    } entry_t;

    localparam reg_t REG_ZERO = '0;
endpackage

// File: rtl/irt_writer_map.sv
// Youngest-writer map: per architectural register, whether a table slot will produce it and which one.
// Two combinational read ports, one insert write port and one conditional retire clear; r0 is never written.
module irt_writer_map
    import irt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  reg_t rd_a_reg,
    output logic rd_a_valid,
    output idx_t rd_a_idx,
    input  reg_t rd_b_reg,
    output logic rd_b_valid,
    output idx_t rd_b_idx,
    input  logic wr_en,
    input  reg_t wr_reg,
    input  idx_t wr_idx,
    input  logic clr_en,
    input  reg_t clr_reg,
    input  idx_t clr_idx
);

    logic [IRT_REGNUM-1:0] wv_q, wv_d;
    idx_t                  widx_q [IRT_REGNUM];
    idx_t                  widx_d [IRT_REGNUM];

    assign rd_a_valid = wv_q[rd_a_reg];
    assign rd_a_idx   = widx_q[rd_a_reg];
    assign rd_b_valid = wv_q[rd_b_reg];
    assign rd_b_idx   = widx_q[rd_b_reg];

    // The write is applied after the clear so a same-cycle insert of the same register wins.
    always_comb begin
        wv_d   = wv_q;
        widx_d = widx_q;
        if (flush) begin
            wv_d = '0;
        end else begin
            if (clr_en && wv_q[clr_reg] && (widx_q[clr_reg] == clr_idx)) begin
                wv_d[clr_reg] = 1'b0;
            end
            if (wr_en && (wr_reg != REG_ZERO)) begin
                wv_d[wr_reg]   = 1'b1;
                widx_d[wr_reg] = wr_idx;
            end
        end
        wv_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wv_q <= '0;
            for (int r = 0; r < IRT_REGNUM; r++) begin
                widx_q[r] <= '0;
            end
        end else begin
            wv_q   <= wv_d;
            widx_q <= widx_d;
        end
    end

endmodule

// File: rtl/irt_dep_table.sv
// Instruction register table: slot storage, RAW dependency masks, readiness and occupancy.
// Optional IRT_FLUSH_EN adds a flush input that empties the table, overriding same-cycle insert/retire.
module irt_dep_table
    import irt_pkg::*;
#(
    parameter int BS     = IRT_BS,
    parameter int REGNUM = IRT_REGNUM
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef IRT_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      ins_valid,
    output logic                      ins_ready,
    input  logic [$clog2(BS)-1:0]     ins_idx,
    input  logic [$clog2(REGNUM)-1:0] ins_rd,
    input  logic [$clog2(REGNUM)-1:0] ins_rs1,
    input  logic [$clog2(REGNUM)-1:0] ins_rs2,
    input  logic                      ret_valid,
    input  logic [$clog2(BS)-1:0]     ret_idx,
    input  logic [$clog2(BS)-1:0]     q_idx,
    output logic                      q_valid,
    output logic [$clog2(REGNUM)-1:0] q_rd,
    output logic [$clog2(REGNUM)-1:0] q_rs1,
    output logic [$clog2(REGNUM)-1:0] q_rs2,
    output logic [BS-1:0]             q_dep,
    output logic [BS-1:0]             entry_ready,
    output logic [$clog2(BS):0]       occupancy
);

    entry_t               slot_q [BS];
    entry_t               slot_d [BS];
    entry_t               look_q, look_d;
    logic [$clog2(BS):0]  occ_q, occ_d;
    logic                 flush_w;
    logic                 ins_fire, ret_fire;
    logic                 rs1_wv, rs2_wv;
    idx_t                 rs1_widx, rs2_widx;
    logic [BS-1:0]        new_dep;

`ifdef IRT_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign ins_ready = ~slot_q[ins_idx].valid & ~rst;
    assign ins_fire  = ins_valid & ins_ready;
    assign ret_fire  = ret_valid & slot_q[ret_idx].valid;

    irt_writer_map u_writer_map (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush_w),
        .rd_a_reg   (ins_rs1),
        .rd_a_valid (rs1_wv),
        .rd_a_idx   (rs1_widx),
        .rd_b_reg   (ins_rs2),
        .rd_b_valid (rs2_wv),
        .rd_b_idx   (rs2_widx),
        .wr_en      (ins_fire),
        .wr_reg     (ins_rd),
        .wr_idx     (ins_idx),
        .clr_en     (ret_fire),
        .clr_reg    (slot_q[ret_idx].rd),
        .clr_idx    (ret_idx)
    );

    // Dependencies use the writer map before this edge's update; a retiring producer is bypassed.
    always_comb begin
        new_dep = '0;
        if ((ins_rs1 != REG_ZERO) && rs1_wv) new_dep[rs1_widx] = 1'b1;
        if ((ins_rs2 != REG_ZERO) && rs2_wv) new_dep[rs2_widx] = 1'b1;
        if (ret_fire)                        new_dep[ret_idx]  = 1'b0;
    end

    always_comb begin
        slot_d = slot_q;
        if (flush_w) begin
            for (int i = 0; i < BS; i++) begin
                slot_d[i].valid = 1'b0;
                slot_d[i].dep   = '0;
            end
        end else begin
            if (ret_fire) begin
                slot_d[ret_idx].valid = 1'b0;
                for (int i = 0; i < BS; i++) begin
                    slot_d[i].dep[ret_idx] = 1'b0;
                end
            end
            if (ins_fire) begin
                slot_d[ins_idx] = '{valid: 1'b1, rd: ins_rd, rs1: ins_rs1,
                                    rs2: ins_rs2, dep: new_dep};
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (flush_w) begin
            occ_d = '0;
        end else begin
            unique case ({ins_fire, ret_fire})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    assign look_d = slot_q[q_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BS; i++) begin
                slot_q[i] <= '0;
            end
            look_q <= '0;
            occ_q  <= '0;
        end else begin
            slot_q <= slot_d;
            look_q <= look_d;
            occ_q  <= occ_d;
        end
    end

    always_comb begin
        entry_ready = '0;
        for (int i = 0; i < BS; i++) begin
            entry_ready[i] = slot_q[i].valid & ~|slot_q[i].dep;
        end
    end

    assign q_valid   = look_q.valid;
    assign q_rd      = look_q.rd;
    assign q_rs1     = look_q.rs1;
    assign q_rs2     = look_q.rs2;
    assign q_dep     = look_q.dep;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_irt_dep_table.sv
// Self-checking bench for irt_dep_table: lookups are scored through an expectation queue,
// readiness/occupancy are compared inline in each scenario task.
module tb_irt_dep_table;
    import irt_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid, ins_ready;
    logic [3:0]  ins_idx, ins_rd, ins_rs1, ins_rs2;
    logic        ret_valid;
    logic [3:0]  ret_idx, q_idx;
    logic        q_valid;
    logic [3:0]  q_rd, q_rs1, q_rs2;
    logic [15:0] q_dep, entry_ready;
    logic [4:0]  occupancy;
`ifdef IRT_FLUSH_EN
    logic        flush;
`endif

    typedef struct {
        int          due;
        int          idx;
        logic        v;
        logic [3:0]  rd, rs1, rs2;
        logic [15:0] dep;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    irt_dep_table dut (
        .clk         (clk),
        .rst         (rst),
`ifdef IRT_FLUSH_EN
        .flush       (flush),
`endif
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_idx     (ins_idx),
        .ins_rd      (ins_rd),
        .ins_rs1     (ins_rs1),
        .ins_rs2     (ins_rs2),
        .ret_valid   (ret_valid),
        .ret_idx     (ret_idx),
        .q_idx       (q_idx),
        .q_valid     (q_valid),
        .q_rd        (q_rd),
        .q_rs1       (q_rs1),
        .q_rs2       (q_rs2),
        .q_dep       (q_dep),
        .entry_ready (entry_ready),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Lookup scoreboard: an expectation is due on the negedge after the capturing edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            vectors++;
            if ({q_valid, q_rd, q_rs1, q_rs2, q_dep} !==
                {mon_e.v, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.dep}) begin
                errors++;
                $display("FAIL lookup[%0d]: got v=%b rd=%0d rs1=%0d rs2=%0d dep=%h, expected v=%b rd=%0d rs1=%0d rs2=%0d dep=%h",
                         mon_e.idx, q_valid, q_rd, q_rs1, q_rs2, q_dep,
                         mon_e.v, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.dep);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ins_valid = 1'b0;
        ret_valid = 1'b0;
`ifdef IRT_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    task automatic set_ins(input int idx, input int rd, input int rs1, input int rs2);
        ins_valid = 1'b1;
        ins_idx   = 4'(idx);
        ins_rd    = 4'(rd);
        ins_rs1   = 4'(rs1);
        ins_rs2   = 4'(rs2);
    endtask

    task automatic set_ret(input int idx);
        ret_valid = 1'b1;
        ret_idx   = 4'(idx);
    endtask

    task automatic push_lookup(input int idx, input logic v, input int rd, input int rs1,
                               input int rs2, input logic [15:0] dep);
        q_idx = 4'(idx);
        sb_q.push_back('{due: cyc + 1, idx: idx, v: v, rd: 4'(rd), rs1: 4'(rs1),
                         rs2: 4'(rs2), dep: dep});
    endtask

    task automatic retire_all();
        for (int i = 0; i < 16; i++) begin
            drive_idle();
            set_ret(i);
            tick();
        end
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        ins_idx = 4'd0; ins_rd = '0; ins_rs1 = '0; ins_rs2 = '0;
        ret_idx = 4'd0; q_idx = 4'd0;
        rst = 1'b1;
        tick(); tick();
        vectors++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        vectors++; if (entry_ready !== 16'h0000) begin errors++; $display("FAIL reset_entry_ready: got %h expected 0000", entry_ready); end
        vectors++; if (ins_ready !== 1'b0) begin errors++; $display("FAIL reset_ins_ready: got %b expected 0", ins_ready); end
        vectors++; if ({q_valid, q_rd, q_rs1, q_rs2, q_dep} !== 29'd0) begin errors++; $display("FAIL reset_q: got v=%b dep=%h expected all 0", q_valid, q_dep); end
        rst = 1'b0;
        tick();
        vectors++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ins_ready: got %b expected 1", ins_ready); end
    endtask

    task automatic test_basic();
        drive_idle(); set_ins(4, 3, 5, 7); #1;
        vectors++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL basic_ins_ready: got %b expected 1", ins_ready); end
        tick(); drive_idle();
        push_lookup(4, 1'b1, 3, 5, 7, 16'h0000);
        vectors++; if (entry_ready !== 16'h0010) begin errors++; $display("FAIL basic_entry_ready: got %h expected 0010", entry_ready); end
        vectors++; if (occupancy !== 5'd1) begin errors++; $display("FAIL basic_occ: got %0d expected 1", occupancy); end
        tick();
    endtask

    task automatic test_raw();
        drive_idle(); set_ins(8, 2, 3, 9); tick(); drive_idle();
        vectors++; if (entry_ready !== 16'h0010) begin errors++; $display("FAIL raw_blocked: got %h expected 0010", entry_ready); end
        push_lookup(8, 1'b1, 2, 3, 9, 16'h0010); tick();
        set_ret(4); tick(); drive_idle();
        vectors++; if (entry_ready !== 16'h0100) begin errors++; $display("FAIL raw_released: got %h expected 0100", entry_ready); end
        vectors++; if (occupancy !== 5'd1) begin errors++; $display("FAIL raw_occ: got %0d expected 1", occupancy); end
        push_lookup(8, 1'b1, 2, 3, 9, 16'h0000); tick();
    endtask

    task automatic test_zero_reg();
        drive_idle(); set_ins(3, 0, 7, 0); tick();
        drive_idle(); set_ins(5, 0, 0, 0); tick(); drive_idle();
        push_lookup(5, 1'b1, 0, 0, 0, 16'h0000);
        vectors++; if (entry_ready !== 16'h0128) begin errors++; $display("FAIL zero_entry_ready: got %h expected 0128", entry_ready); end
        vectors++; if (occupancy !== 5'd3) begin errors++; $display("FAIL zero_occ: got %0d expected 3", occupancy); end
        tick();
        push_lookup(3, 1'b1, 0, 7, 0, 16'h0000); tick();
        retire_all();
        vectors++; if (occupancy !== 5'd0) begin errors++; $display("FAIL zero_cleanup_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_bypass();
        drive_idle(); set_ins(4, 3, 0, 0); tick();
        drive_idle(); set_ret(4); set_ins(2, 1, 3, 0); tick(); drive_idle();
        push_lookup(2, 1'b1, 1, 3, 0, 16'h0000);
        vectors++; if (entry_ready !== 16'h0004) begin errors++; $display("FAIL bypass_entry_ready: got %h expected 0004", entry_ready); end
        vectors++; if (occupancy !== 5'd1) begin errors++; $display("FAIL bypass_occ: got %0d expected 1", occupancy); end
        tick();
        set_ins(7, 3, 0, 0); tick();
        drive_idle(); set_ret(7); set_ins(6, 3, 0, 0); tick();
        drive_idle(); set_ins(9, 4, 3, 0); tick(); drive_idle();
        push_lookup(9, 1'b1, 4, 3, 0, 16'h0040);
        vectors++; if (entry_ready !== 16'h0044) begin errors++; $display("FAIL insert_wins_entry_ready: got %h expected 0044", entry_ready); end
        vectors++; if (occupancy !== 5'd3) begin errors++; $display("FAIL insert_wins_occ: got %0d expected 3", occupancy); end
        tick();
        retire_all();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive_idle(); set_ins(i, i, 0, 0); tick();
        end
        drive_idle();
        vectors++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_occ: got %0d expected 16", occupancy); end
        vectors++; if (entry_ready !== 16'hFFFF) begin errors++; $display("FAIL full_entry_ready: got %h expected ffff", entry_ready); end
        for (int i = 0; i < 16; i++) begin
            ins_idx = 4'(i); #1;
            vectors++; if (ins_ready !== 1'b0) begin errors++; $display("FAIL full_ins_ready[%0d]: got %b expected 0", i, ins_ready); end
        end
        tick();
        set_ins(5, 9, 1, 0); tick(); drive_idle();
        push_lookup(5, 1'b1, 5, 0, 0, 16'h0000); tick();
        vectors++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_stall_occ: got %0d expected 16", occupancy); end
        set_ret(0); tick(); drive_idle();
        ins_idx = 4'd0; #1;
        vectors++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL full_freed_ins_ready: got %b expected 1", ins_ready); end
        vectors++; if (occupancy !== 5'd15) begin errors++; $display("FAIL full_freed_occ: got %0d expected 15", occupancy); end
        tick();
        set_ret(0); tick(); drive_idle();
        vectors++; if (occupancy !== 5'd15) begin errors++; $display("FAIL invalid_retire_occ: got %0d expected 15", occupancy); end
        vectors++; if (entry_ready !== 16'hFFFE) begin errors++; $display("FAIL invalid_retire_entry_ready: got %h expected fffe", entry_ready); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; #1;
        vectors++; if (occupancy !== 5'd0) begin errors++; $display("FAIL async_reset_occ: got %0d expected 0", occupancy); end
        tick(); rst = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            drive_idle(); set_ins(i, i + 1, i, 0); tick();
        end
        drive_idle();
        vectors++; if (occupancy !== 5'd5) begin errors++; $display("FAIL chain_occ: got %0d expected 5", occupancy); end
        vectors++; if (entry_ready !== 16'h0001) begin errors++; $display("FAIL chain_entry_ready: got %h expected 0001", entry_ready); end
        ins_idx = 4'd9;
        #2 rst = 1'b1; #1;
        vectors++; if (occupancy !== 5'd0) begin errors++; $display("FAIL mid_reset_occ: got %0d expected 0", occupancy); end
        vectors++; if (entry_ready !== 16'h0000) begin errors++; $display("FAIL mid_reset_entry_ready: got %h expected 0000", entry_ready); end
        vectors++; if (ins_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ins_ready: got %b expected 0", ins_ready); end
        vectors++; if (q_valid !== 1'b0 || q_dep !== 16'h0000) begin errors++; $display("FAIL mid_reset_q: got v=%b dep=%h expected 0/0000", q_valid, q_dep); end
        tick(); rst = 1'b0; tick();
        vectors++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL post_mid_reset_ins_ready: got %b expected 1", ins_ready); end
        set_ins(1, 7, 3, 2); tick(); drive_idle();
        push_lookup(1, 1'b1, 7, 3, 2, 16'h0000); tick();
        vectors++; if (occupancy !== 5'd1) begin errors++; $display("FAIL post_mid_reset_occ: got %0d expected 1", occupancy); end
    endtask

`ifdef IRT_FLUSH_EN
    task automatic test_flush();
        drive_idle(); set_ins(2, 5, 7, 0); tick(); drive_idle();
        vectors++; if (entry_ready !== 16'h0002) begin errors++; $display("FAIL pre_flush_entry_ready: got %h expected 0002", entry_ready); end
        flush = 1'b1; set_ins(9, 3, 5, 0); tick(); drive_idle();
        vectors++; if (occupancy !== 5'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
        vectors++; if (entry_ready !== 16'h0000) begin errors++; $display("FAIL flush_entry_ready: got %h expected 0000", entry_ready); end
        set_ins(4, 1, 7, 5); tick(); drive_idle();
        push_lookup(4, 1'b1, 1, 7, 5, 16'h0000); tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_zero_reg();
        test_bypass();
        test_full();
        test_reset_mid();
`ifdef IRT_FLUSH_EN
        test_flush();
`endif
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
